// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external combinational ALU between two requesters
// using round-robin arbitration.
//
// Each requester offers {sel, a, b} on a valid/ready handshake. A granted
// operation is held in the alu_sel/alu_a/alu_b registers for one EXEC cycle.
// The ALU result and flags are then captured into the rsp_* registers and
// returned on a single response channel tagged with the requester ID.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   reqN_valid/ready         request handshake for requester N (N = 0, 1)
//   reqN_sel/a/b             opcode and operands for requester N
//   alu_sel/a/b              registered drive to the ALU inputs
//   alu_out, alu_*           ALU result and flags (error, zero, carry, overflow)
//   rsp_valid/ready          response handshake
//   rsp_id                   requester that issued the response
//   rsp_out, rsp_*           registered ALU result and flags
//   busy                     high whenever the arbiter is not idle
//
// Optional build macro ALU_RR_ARBITER_STATS_EN adds the saturating CNT_W-bit
// counters stat_done0, stat_done1 and stat_err, which count response handshakes.
module alu_rr_arbiter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SEL_W-1:0] req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [SEL_W-1:0] alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_error,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_error,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,

`ifdef ALU_RR_ARBITER_STATS_EN
  output logic [CNT_W-1:0] stat_done0,
  output logic [CNT_W-1:0] stat_done1,
  output logic [CNT_W-1:0] stat_err,
`endif

  output logic             busy
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_width_check
    $error("WIDTH must be at least 1");
  end
  if (SEL_W < 1) begin : g_sel_w_check
    $error("SEL_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             issue_id_q, issue_id_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  // {error, zero, carry, overflow}
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic             grant_valid;
  logic             grant_id;
  logic [SEL_W-1:0] grant_sel;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;

  // Grant selection. Ready is only offered in IDLE and never while reset is
  // asserted, so the combinational ready outputs read 0 during reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = rr_ptr_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign grant_sel = grant_id ? req1_sel : req0_sel;
  assign grant_a   = grant_id ? req1_a   : req0_a;
  assign grant_b   = grant_id ? req1_b   : req0_b;

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid &&  grant_id;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    issue_id_d  = issue_id_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          alu_sel_d  = grant_sel;
          alu_a_d    = grant_a;
          alu_b_d    = grant_b;
          issue_id_d = grant_id;
          // The other requester wins the next tie.
          rr_ptr_d   = ~grant_id;
          state_d    = StExec;
        end
      end
      StExec: begin
        rsp_out_d   = alu_out;
        rsp_flags_d = {alu_error, alu_zero, alu_carry, alu_overflow};
        rsp_id_d    = issue_id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE, dropping any response.
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      issue_id_q  <= 1'b0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      issue_id_q  <= issue_id_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_sel      = alu_sel_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_out      = rsp_out_q;
  assign rsp_error    = rsp_flags_q[3];
  assign rsp_zero     = rsp_flags_q[2];
  assign rsp_carry    = rsp_flags_q[1];
  assign rsp_overflow = rsp_flags_q[0];
  assign busy         = (state_q != StIdle);

`ifdef ALU_RR_ARBITER_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             rsp_hs;
  logic [CNT_W-1:0] done0_q, done0_d;
  logic [CNT_W-1:0] done1_q, done1_d;
  logic [CNT_W-1:0] err_q, err_d;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    done0_d = done0_q;
    done1_d = done1_q;
    err_d   = err_q;
    if (rsp_hs) begin
      if (!rsp_id_q && !(&done0_q)) begin
        done0_d = done0_q + CntOne;
      end
      if (rsp_id_q && !(&done1_q)) begin
        done1_d = done1_q + CntOne;
      end
      if (rsp_flags_q[3] && !(&err_q)) begin
        err_d = err_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_q <= '0;
      done1_q <= '0;
      err_q   <= '0;
    end else begin
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

  assign stat_done0 = done0_q;
  assign stat_done1 = done1_q;
  assign stat_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter. A behavioural 2-bit ALU stub is
// wired to the DUT's ALU port. Expected values come from constants and from a
// transaction-level model of grant order and response timing.
module tb_alu_rr_arbiter;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [SEL_W-1:0] OP_AND = 4'd0;
  localparam logic [SEL_W-1:0] OP_OR  = 4'd1;
  localparam logic [SEL_W-1:0] OP_XOR = 4'd2;
  localparam logic [SEL_W-1:0] OP_ADD = 4'd3;
  localparam logic [SEL_W-1:0] OP_SUB = 4'd4;
  localparam logic [SEL_W-1:0] OP_BAD = 4'd15;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [SEL_W-1:0] req0_sel;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [SEL_W-1:0] req1_sel;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_error, alu_zero, alu_carry, alu_overflow;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_error, rsp_zero, rsp_carry, rsp_overflow;
  logic             busy;
`ifdef ALU_RR_ARBITER_STATS_EN
  logic [CNT_W-1:0] stat_done0, stat_done1, stat_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_rr_arbiter #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_sel    (req0_sel),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_sel    (req1_sel),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .alu_sel     (alu_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .alu_error   (alu_error),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_out     (rsp_out),
    .rsp_error   (rsp_error),
    .rsp_zero    (rsp_zero),
    .rsp_carry   (rsp_carry),
    .rsp_overflow(rsp_overflow),
`ifdef ALU_RR_ARBITER_STATS_EN
    .stat_done0  (stat_done0),
    .stat_done1  (stat_done1),
    .stat_err    (stat_err),
`endif
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference 2-bit ALU: returns {error, zero, carry, overflow, out}.
  function automatic logic [5:0] alu_ref(input logic [SEL_W-1:0] sel,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    int s;
    logic [1:0] o;
    logic e, c, v;
    e = 1'b0; c = 1'b0; v = 1'b0; o = 2'd0; s = 0;
    case (sel)
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_ADD: begin
        s = int'(a) + int'(b);
        o = 2'(s);
        c = (s > 3);
        v = (a[1] == b[1]) && (o[1] != a[1]);
      end
      OP_SUB: begin
        s = int'(a) - int'(b);
        o = 2'(s);
        c = (s < 0);
        v = (a[1] != b[1]) && (o[1] != a[1]);
      end
      default: e = 1'b1;
    endcase
    return {e, (o == 2'd0), c, v, o};
  endfunction

  always_comb {alu_error, alu_zero, alu_carry, alu_overflow, alu_out} =
      alu_ref(alu_sel, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_sel = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_sel = '0; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] exp_rsp;
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_sel = 4'($urandom); req0_a = 2'($urandom);
      req0_b = 2'($urandom);
      req1_valid = 1'($urandom); req1_sel = 4'($urandom); req1_a = 2'($urandom);
      req1_b = 2'($urandom); rsp_ready = 1'($urandom);
      #1;
      n_tests++;
      if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_out, rsp_error, rsp_zero,
           rsp_carry, rsp_overflow, alu_sel, alu_a, alu_b} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got ready=%b%b busy=%b rsp_valid=%b out=%0d alu=%h/%0d/%0d, want all 0",
                 i, req0_ready, req1_ready, busy, rsp_valid, rsp_out, alu_sel, alu_a, alu_b);
      end
`ifdef ALU_RR_ARBITER_STATS_EN
      n_tests++;
      if ({stat_done0, stat_done1, stat_err} !== '0) begin
        n_fail++;
        $display("FAIL reset_stats: got %0d/%0d/%0d, want 0/0/0", stat_done0, stat_done1, stat_err);
      end
`endif
      tick();
    end
    clear_inputs();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_sel = OP_ADD; req0_a = 2'd1; req0_b = 2'd2;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_ready: got %b%b, want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    n_tests++;
    if ({busy, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_exec: got busy=%b rsp_valid=%b, want 1 0", busy, rsp_valid);
    end
    tick();
    #1;
    // {valid, id, error, zero, carry, overflow, out} plus alu inputs held
    exp_rsp = {1'b1, 1'b0, 4'b0000, 2'd3, OP_ADD[1:0], 2'd1, 2'd2};
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_error, rsp_zero, rsp_carry, rsp_overflow, rsp_out,
         alu_sel[1:0], alu_a, alu_b} !== exp_rsp) begin
      n_fail++;
      $display("FAIL reset_first_rsp: got v=%b id=%b flags=%b%b%b%b out=%0d, want v=1 id=0 flags=0000 out=3",
               rsp_valid, rsp_id, rsp_error, rsp_zero, rsp_carry, rsp_overflow, rsp_out);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, busy, rsp_out} !== {1'b0, 1'b0, 2'd3}) begin
      n_fail++;
      $display("FAIL reset_rsp_done: got v=%b busy=%b out=%0d, want 0 0 3", rsp_valid, busy, rsp_out);
    end
  endtask

  task automatic test_fairness();
    logic exp_id;
    bit   slot0, slot2;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_sel = OP_AND; req0_a = 2'd3; req0_b = 2'd1;
    req1_valid = 1'b1; req1_sel = OP_XOR; req1_a = 2'd2; req1_b = 2'd3;
    for (int t = 0; t < 18; t++) begin
      #1;
      exp_id = 1'((t / 3) % 2);
      slot0  = (t % 3 == 0);
      slot2  = (t % 3 == 2);
      n_tests++;
      if ({req0_ready, req1_ready} !== {slot0 && !exp_id, slot0 && exp_id}) begin
        n_fail++;
        $display("FAIL fair_ready t=%0d: got %b%b, want %b%b", t, req0_ready, req1_ready,
                 slot0 && !exp_id, slot0 && exp_id);
      end
      n_tests++;
      if (slot2 ? ({rsp_valid, rsp_id, rsp_out} !== {1'b1, exp_id, 2'd1}) : (rsp_valid !== 1'b0))
      begin
        n_fail++;
        $display("FAIL fair_rsp t=%0d: got v=%b id=%b out=%0d, want v=%b id=%b out=1", t, rsp_valid,
                 rsp_id, rsp_out, slot2, exp_id);
      end
      tick();
    end
    clear_inputs();
    rsp_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1'b1; req1_sel = OP_ADD; req1_a = 2'd3; req1_b = 2'd3;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: got %b%b, want 01", req0_ready, req1_ready);
    end
    tick();
    // Both keep requesting; neither may be accepted until the response drains.
    req0_valid = 1'b1; req0_sel = OP_OR; req0_a = 2'd1; req0_b = 2'd2;
    req1_sel = OP_SUB;
    tick();
    for (int i = 0; i < 6; i++) begin
      rsp_ready = (i == 5);
      req0_a = 2'($urandom); req1_b = 2'($urandom);
      #1;
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_error, req0_ready, req1_ready} !==
          {1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold i=%0d: got v=%b id=%b out=%0d c=%b ready=%b%b, want 1 1 2 1 00", i,
                 rsp_valid, rsp_id, rsp_out, rsp_carry, req0_ready, req1_ready);
      end
      tick();
    end
    rsp_ready = 1'b0;
    #1;
    n_tests++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b ready=%b%b, want v=0 ready=10", rsp_valid, req0_ready,
               req1_ready);
    end
    clear_inputs();
    rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_invalid_op();
    do_reset();
    req0_valid = 1'b1; req0_sel = OP_BAD; req0_a = 2'($urandom); req0_b = 2'($urandom);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_error, rsp_out, rsp_zero} !== {1'b1, 1'b0, 1'b1, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL invalid_op: got v=%b id=%b err=%b out=%0d zero=%b, want 1 0 1 0 1", rsp_valid,
               rsp_id, rsp_error, rsp_out, rsp_zero);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef ALU_RR_ARBITER_STATS_EN
    #1;
    n_tests++;
    if ({stat_err, stat_done0, stat_done1} !== {2'd1, 2'd1, 2'd0}) begin
      n_fail++;
      $display("FAIL invalid_stats: got err=%0d d0=%0d d1=%0d, want 1 1 0", stat_err, stat_done0,
               stat_done1);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0_valid = 1'b1; req0_sel = OP_ADD; req0_a = 2'd1; req0_b = 2'd1;
    tick();
    req0_valid = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_exec_busy: got %b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_exec: got busy=%b v=%b, want 00", busy, rsp_valid);
    end
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req1_sel = OP_OR;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_exec_grant: got %b%b, want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    #1;
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_resp_valid: got %b, want 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_resp: got busy=%b v=%b ready=%b%b, want 0000", busy, rsp_valid,
               req0_ready, req1_ready);
    end
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_resp_grant: got %b%b, want 10", req0_ready, req1_ready);
    end
    tick();
    clear_inputs();
    rsp_ready = 1'b1;
    repeat (3) tick();
  endtask

`ifdef ALU_RR_ARBITER_STATS_EN
  task automatic test_stats_saturate();
    do_reset();
    rsp_ready = 1'b1;
    req0_sel = OP_ADD; req0_a = 2'd1; req0_b = 2'd0;
    for (int t = 0; t < 15; t++) begin
      req0_valid = (t < 13);
      if (t == 9) begin
        #1;
        n_tests++;
        if (stat_done0 !== 2'd3) begin
          n_fail++;
          $display("FAIL stats_three: got %0d, want 3", stat_done0);
        end
      end
      tick();
    end
    #1;
    n_tests++;
    if ({stat_done0, stat_done1, stat_err} !== {2'd3, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL stats_saturate: got d0=%0d d1=%0d err=%0d, want 3 0 0", stat_done0,
               stat_done1, stat_err);
    end
    clear_inputs();
  endtask
`endif

  // Random traffic against a transaction-level model: the arbiter is either
  // free or owns one operation; a response appears two cycles after its grant
  // and stays until accepted.
  task automatic test_random();
    bit               m_busy, m_ptr, exp_rv, g_valid, g_id;
    int               m_grant_cyc, done0, done1, errc;
    logic [5:0]       pend_res, shown_res;
    logic             pend_id, shown_id;
    logic [SEL_W-1:0] exp_sel;
    logic [WIDTH-1:0] exp_a, exp_b;
    do_reset();
    m_busy = 0; m_ptr = 0; m_grant_cyc = 0; done0 = 0; done1 = 0; errc = 0;
    pend_res = '0; shown_res = '0; pend_id = 0; shown_id = 0;
    exp_sel = '0; exp_a = '0; exp_b = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_sel = 4'($urandom_range(0, 6)); req0_a = 2'($urandom); req0_b = 2'($urandom);
      req1_sel = 4'($urandom_range(0, 6)); req1_a = 2'($urandom); req1_b = 2'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      exp_rv = m_busy && (cyc >= m_grant_cyc + 2);
      if (exp_rv) begin
        shown_res = pend_res;
        shown_id  = pend_id;
      end
      g_valid = !m_busy && (req0_valid || req1_valid);
      g_id    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      n_tests++;
      if ({req0_ready, req1_ready, busy} !== {g_valid && !g_id, g_valid && g_id, m_busy}) begin
        n_fail++;
        $display("FAIL rand_ready cyc=%0d: got ready=%b%b busy=%b, want %b%b %b", cyc, req0_ready,
                 req1_ready, busy, g_valid && !g_id, g_valid && g_id, m_busy);
      end
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_error, rsp_zero, rsp_carry, rsp_overflow, rsp_out} !==
          {exp_rv, shown_id, shown_res}) begin
        n_fail++;
        $display("FAIL rand_rsp cyc=%0d: got v=%b id=%b flags/out=%b%b%b%b_%b, want v=%b id=%b %b",
                 cyc, rsp_valid, rsp_id, rsp_error, rsp_zero, rsp_carry, rsp_overflow, rsp_out,
                 exp_rv, shown_id, shown_res);
      end
      n_tests++;
      if ({alu_sel, alu_a, alu_b} !== {exp_sel, exp_a, exp_b}) begin
        n_fail++;
        $display("FAIL rand_alu_in cyc=%0d: got %h/%0d/%0d, want %h/%0d/%0d", cyc, alu_sel, alu_a,
                 alu_b, exp_sel, exp_a, exp_b);
      end
`ifdef ALU_RR_ARBITER_STATS_EN
      n_tests++;
      if ({stat_done0, stat_done1, stat_err} !== {2'(done0), 2'(done1), 2'(errc)}) begin
        n_fail++;
        $display("FAIL rand_stats cyc=%0d: got %0d/%0d/%0d, want %0d/%0d/%0d", cyc, stat_done0,
                 stat_done1, stat_err, done0, done1, errc);
      end
`endif
      if (exp_rv && rsp_ready) begin
        m_busy = 0;
        if (!shown_id && done0 < CNT_MAX) done0++;
        if (shown_id && done1 < CNT_MAX) done1++;
        if (shown_res[5] && errc < CNT_MAX) errc++;
      end
      if (g_valid) begin
        m_busy      = 1;
        m_grant_cyc = cyc;
        m_ptr       = !g_id;
        pend_id     = g_id;
        exp_sel     = g_id ? req1_sel : req0_sel;
        exp_a       = g_id ? req1_a : req0_a;
        exp_b       = g_id ? req1_b : req0_b;
        pend_res    = alu_ref(exp_sel, exp_a, exp_b);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_invalid_op();
    test_reset_mid_op();
`ifdef ALU_RR_ARBITER_STATS_EN
    test_stats_saturate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
